// File: rtl/adder_sum_accumulator_if.sv
// Handshake bundle between the upstream adder/consumer and the batch accumulator.
// The master side drives valid, c and sum_ready. The slave side returns the batch sum and status.
interface adder_sum_accumulator_if #(
  parameter int unsigned SUM_W = 12
);

  logic             valid;
  logic [6:0]       c;
  logic [SUM_W-1:0] sum_data;
  logic             sum_valid;
  logic             sum_ready;
  logic [3:0]       sample_cnt;
  logic             overrun;

  modport master (
    output valid, c, sum_ready,
    input  sum_data, sum_valid, sample_cnt, overrun
  );

  modport slave (
    input  valid, c, sum_ready,
    output sum_data, sum_valid, sample_cnt, overrun
  );

endinterface

// File: rtl/adder_sum_accumulator.sv
// Sums NUM_SAMPLES consecutive adder results into one batch sum.
// The result is offered to a consumer through a valid/ready handshake, and a sticky overrun flag is kept.
module adder_sum_accumulator #(
  parameter int unsigned NUM_SAMPLES = 4,
  parameter int unsigned SUM_W       = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  adder_sum_accumulator_if.slave bus
);

  localparam int unsigned C_W       = 7;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MIN_SUM_W = C_W + $clog2(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  generate
    if (NUM_SAMPLES < 2 || NUM_SAMPLES > 16) begin : g_bad_num_samples
      $error("adder_sum_accumulator: NUM_SAMPLES must be in 2..16");
    end
    if (SUM_W < MIN_SUM_W) begin : g_bad_sum_w
      $error("adder_sum_accumulator: SUM_W too narrow for NUM_SAMPLES");
    end
  endgenerate

  typedef enum logic {ACC_IDLE = 1'b0, ACC_RUN  = 1'b1} acc_state_t;
  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

  acc_state_t       r_acc_state;
  acc_state_t       w_acc_state_nxt;
  out_state_t       r_out_state;
  out_state_t       w_out_state_nxt;

  logic             r_valid_d;
  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [SUM_W-1:0] r_sum_data;
  logic             r_sum_valid;
  logic             r_overrun;

  logic [SUM_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_sample_cnt_nxt;
  logic [SUM_W-1:0] w_sum_data_nxt;
  logic             w_sum_valid_nxt;
  logic             w_overrun_nxt;

  logic             w_sample;
  logic             w_last;
  logic             w_hs;
  logic [SUM_W-1:0] w_cand;

  // c belongs to the valid seen one cycle earlier, so the sample strike is the delayed strobe
  assign w_sample = r_valid_d;
  assign w_last   = w_sample && (r_sample_cnt == LAST_CNT);
  assign w_hs     = (r_out_state == OUT_FULL) && bus.sum_ready;
  assign w_cand   = r_acc + SUM_W'(bus.c);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_state  <= ACC_IDLE;
      r_out_state  <= OUT_EMPTY;
      r_valid_d    <= 1'b0;
      r_acc        <= '0;
      r_sample_cnt <= '0;
      r_sum_data   <= '0;
      r_sum_valid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_acc_state  <= w_acc_state_nxt;
      r_out_state  <= w_out_state_nxt;
      r_valid_d    <= bus.valid;
      r_acc        <= w_acc_nxt;
      r_sample_cnt <= w_sample_cnt_nxt;
      r_sum_data   <= w_sum_data_nxt;
      r_sum_valid  <= w_sum_valid_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  // Next-state logic for both the accumulate side and the output side
  always_comb begin
    w_acc_state_nxt = r_acc_state;
    w_out_state_nxt = r_out_state;

    case (r_acc_state)
      ACC_IDLE: if (w_sample) w_acc_state_nxt = w_last ? ACC_IDLE : ACC_RUN;
      ACC_RUN:  if (w_last)   w_acc_state_nxt = ACC_IDLE;
      default:  w_acc_state_nxt = ACC_IDLE;
    endcase

    // A completion in FULL keeps the slot full, whether the new sum is taken or dropped
    case (r_out_state)
      OUT_EMPTY: if (w_last) w_out_state_nxt = OUT_FULL;
      OUT_FULL:  if (w_hs && !w_last) w_out_state_nxt = OUT_EMPTY;
      default:   w_out_state_nxt = OUT_EMPTY;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    w_acc_nxt        = r_acc;
    w_sample_cnt_nxt = r_sample_cnt;
    w_sum_data_nxt   = r_sum_data;
    w_overrun_nxt    = r_overrun;
    w_sum_valid_nxt  = (w_out_state_nxt == OUT_FULL);

    if (w_sample) begin
      if (w_last) begin
        w_acc_nxt        = '0;
        w_sample_cnt_nxt = '0;
      end else begin
        w_acc_nxt        = w_cand;
        w_sample_cnt_nxt = r_sample_cnt + CNT_W'(1);
      end
    end

    if (w_last && ((r_out_state == OUT_EMPTY) || w_hs)) begin
      w_sum_data_nxt = w_cand;
    end

    if (w_last && (r_out_state == OUT_FULL) && !bus.sum_ready) begin
      w_overrun_nxt = 1'b1;
    end
  end

  assign bus.sum_data   = r_sum_data;
  assign bus.sum_valid  = r_sum_valid;
  assign bus.sample_cnt = r_sample_cnt;
  assign bus.overrun    = r_overrun;

endmodule
